// File: rtl/ap_handshake_perf_monitor_if.sv
// Signal bundle between the monitored design and ap_handshake_perf_monitor.
// The master drives the handshake, control and read-request signals.
// The slave (the monitor) returns the read data and status flags.
interface ap_handshake_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 4
) ();

  logic              clear;
  logic              finish;
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] overflow;
  logic              frozen;

  modport master (
    output clear, finish, ap_start, ap_ready, ap_done, ap_continue,
           rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, overflow, frozen
  );

  modport slave (
    input  clear, finish, ap_start, ap_ready, ap_done, ap_continue,
           rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, overflow, frozen
  );

endinterface

// File: rtl/ap_handshake_perf_monitor.sv
// Multi-channel ap_* handshake performance monitor.
// Every accepted start is timestamped into a per-channel FIFO, so pipelined
// blocks with several transactions in flight are measured correctly. Each
// done pops the oldest timestamp. The monitor keeps saturating counts,
// busy/stall cycle counts and last/min/max latency per channel. These are
// read back one word at a time through a registered select port.
module ap_handshake_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 8,
  parameter int CH_W   = 4
) (
  input logic clock,
  input logic reset,
  ap_handshake_perf_monitor_if.slave bus
);

  localparam int AW = $clog2(DEPTH);  // FIFO pointer width
  localparam int OW = AW + 1;         // occupancy width, counts 0..DEPTH

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_STALL = 2'd2
  } ch_state_e;

  // Saturating increment: statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ALL_ONES) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0]  ts;
  logic              frozen_q;
  logic [CNT_W-1:0]  ch_rd [NUM_CH];
  logic [NUM_CH-1:0] ovf_vec;
  logic [CNT_W-1:0]  rd_mux;

  assign bus.frozen   = frozen_q;
  assign bus.overflow = ovf_vec;

  // Free-running timestamp and the sticky freeze flag.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts       <= '0;
      frozen_q <= 1'b0;
    end else if (bus.clear) begin
      ts       <= '0;
      frozen_q <= 1'b0;
    end else begin
      if (!frozen_q) ts <= ts + 1'b1;
      if (bus.finish) frozen_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             ovf;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] last_lat;
    logic [CNT_W-1:0] min_lat;
    logic [CNT_W-1:0] max_lat;

    logic             acc;
    logic             dn;
    logic             empty;
    logic             full;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             lat_valid;
    logic [CNT_W-1:0] lat;
    ch_state_e        state;
    logic [CNT_W-1:0] rd_val;

    assign acc    = bus.ap_start[c] & bus.ap_ready[c];
    assign dn     = bus.ap_done[c] & bus.ap_continue[c];
    assign empty  = (occ == '0);
    assign full   = (occ == OW'(DEPTH));
    assign pop    = dn & ~empty;
    // Accept and done together on an empty FIFO form a zero-latency
    // transaction. Nothing is stored for it.
    assign bypass = acc & dn & empty;
    // A simultaneous pop frees the slot, so a full FIFO still takes the push.
    assign push   = acc & ~bypass & (~full | pop);
    assign lat_valid = pop | bypass;
    assign lat    = pop ? (ts - mem[rd_ptr]) : '0;

    // Stall wins over busy: a done waiting on continue is backpressure.
    assign state = (bus.ap_done[c] & ~bus.ap_continue[c]) ? ST_STALL :
                   empty                                  ? ST_IDLE  :
                                                            ST_BUSY;

    assign ovf_vec[c] = ovf;

    // Timestamp storage. Entries beyond the occupancy are never read.
    // NOTE: the FIFO array has no reset; the pointers and occupancy define
    // validity, so the array can map to plain RAM without reset logic.
    always_ff @(posedge clock) begin
      if (push && !frozen_q && !bus.clear) mem[wr_ptr] <= ts;
    end

    // FIFO bookkeeping and per-channel statistics.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        ovf       <= 1'b0;
        acc_cnt   <= '0;
        done_cnt  <= '0;
        busy_cnt  <= '0;
        stall_cnt <= '0;
        last_lat  <= '0;
        min_lat   <= ALL_ONES;
        max_lat   <= '0;
      end else if (bus.clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        ovf       <= 1'b0;
        acc_cnt   <= '0;
        done_cnt  <= '0;
        busy_cnt  <= '0;
        stall_cnt <= '0;
        last_lat  <= '0;
        min_lat   <= ALL_ONES;
        max_lat   <= '0;
      end else if (!frozen_q) begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;

        if (acc && full && !pop) ovf <= 1'b1;
        if (acc) acc_cnt  <= sat_inc(acc_cnt);
        if (dn)  done_cnt <= sat_inc(done_cnt);
        if (state == ST_BUSY)  busy_cnt  <= sat_inc(busy_cnt);
        if (state == ST_STALL) stall_cnt <= sat_inc(stall_cnt);

        if (lat_valid) begin
          last_lat <= lat;
          if (lat < min_lat) min_lat <= lat;
          if (lat > max_lat) max_lat <= lat;
        end
      end
    end

    // Statistic selected by rd_sel for this channel.
    // NOTE: rd_val gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      rd_val = '0;
      case (bus.rd_sel)
        3'd0: rd_val = acc_cnt;
        3'd1: rd_val = done_cnt;
        3'd2: rd_val = busy_cnt;
        3'd3: rd_val = stall_cnt;
        3'd4: rd_val = last_lat;
        3'd5: rd_val = min_lat;
        3'd6: rd_val = max_lat;
        default: begin
          rd_val[OW-1:0]    = occ;
          rd_val[OW+1:OW]   = state;
          rd_val[OW+2]      = ovf;
        end
      endcase
    end

    assign ch_rd[c] = rd_val;

  end : g_ch

  // Channel select. An unpopulated rd_ch falls through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_ch == CH_W'(c)) rd_mux = ch_rd[c];
    end
  end

  // Registered readout: data is captured at the rd_en edge, so it reflects
  // statistics before that edge's update. It stays readable while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else if (bus.clear) begin
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ap_handshake_perf_monitor.sv
// Self-checking bench for ap_handshake_perf_monitor.
// Read requests push their expected value onto a scoreboard. A monitor pops
// and compares whenever rd_valid is seen.
module tb_ap_handshake_perf_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 4;
  localparam logic [CNT_W-1:0] ONES = '1;

  typedef struct {
    int               ch;
    int               sel;
    logic [CNT_W-1:0] exp;
    string            name;
  } rd_vec_t;

  typedef struct {
    logic [CNT_W-1:0] exp;
    string            name;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  sb_t     sb_q[$];
  rd_vec_t tbl[$];

  always #5 clock = ~clock;

  ap_handshake_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  ap_handshake_perf_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEPTH(DEPTH), .CH_W(CH_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compares every returned read word in order.
  always @(negedge clock) begin
    if (!reset && bus.rd_valid === 1'b1) begin
      sb_t e;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", bus.rd_data);
      end else begin
        e = sb_q.pop_front();
        check(e.name, bus.rd_data, e.exp);
      end
    end
  end

  // One clock of handshake stimulus; returns at the next falling edge.
  task automatic cyc(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] dn,
                     input logic [NUM_CH-1:0] ct);
    bus.ap_start    = st;
    bus.ap_done     = dn;
    bus.ap_continue = ct;
    @(negedge clock);
    bus.rd_en = 1'b0;
  endtask

  task automatic idle();
    cyc('0, '0, '1);
  endtask

  // Arms a read for the next clock edge and records its expected value.
  task automatic req_read(input int ch, input int sel,
                          input logic [CNT_W-1:0] exp, input string name);
    sb_t e;
    bus.rd_en  = 1'b1;
    bus.rd_ch  = CH_W'(ch);
    bus.rd_sel = 3'(sel);
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic add(input int ch, input int sel, input logic [CNT_W-1:0] exp,
                     input string name);
    rd_vec_t v;
    v.ch = ch; v.sel = sel; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Applies the queued read table on idle cycles, then empties it.
  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      req_read(tbl[i].ch, tbl[i].sel, tbl[i].exp, tbl[i].name);
      idle();
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.clear       = 1'b0;
    bus.finish      = 1'b0;
    bus.ap_start    = '0;
    bus.ap_ready    = '1;
    bus.ap_done     = '0;
    bus.ap_continue = '1;
    bus.rd_en       = 1'b0;
    bus.rd_ch       = '0;
    bus.rd_sel      = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("reset_rd_valid", CNT_W'(bus.rd_valid), '0);
    check("reset_rd_data", bus.rd_data, '0);
    check("reset_overflow", CNT_W'(bus.overflow), '0);
    check("reset_frozen", CNT_W'(bus.frozen), '0);
    add(0, 5, ONES, "reset_min_lat");
    add(0, 7, 0, "reset_status");
    run_tbl();

    // ch0 single transaction: latency 12
    cyc(4'b0001, '0, '1);
    repeat (11) idle();
    cyc('0, 4'b0001, '1);

    // ch1 pipelined: accepts k0..k2, dones k10, k12, k13
    repeat (3) cyc(4'b0010, '0, '1);
    req_read(1, 7, 32'h13, "ch1_status_occ3");
    idle();
    repeat (6) idle();
    cyc('0, 4'b0010, '1);
    idle();
    cyc('0, 4'b0010, '1);
    cyc('0, 4'b0010, '1);

    add(0, 0, 1,  "ch0_accepts");
    add(0, 1, 1,  "ch0_dones");
    add(0, 2, 12, "ch0_busy");
    add(0, 3, 0,  "ch0_stall");
    add(0, 4, 12, "ch0_last_lat");
    add(0, 5, 12, "ch0_min_lat");
    add(0, 6, 12, "ch0_max_lat");
    add(0, 7, 0,  "ch0_status");
    add(1, 0, 3,  "ch1_accepts");
    add(1, 1, 3,  "ch1_dones");
    add(1, 2, 13, "ch1_busy");
    add(1, 4, 11, "ch1_last_lat");
    add(1, 5, 10, "ch1_min_lat");
    add(1, 6, 11, "ch1_max_lat");
    add(1, 7, 0,  "ch1_status");
    run_tbl();

    // ch2 overflow: nine accepts into an eight-deep FIFO
    repeat (9) cyc(4'b0100, '0, '1);
    check("ovf_flag", CNT_W'(bus.overflow), 32'h4);
    req_read(2, 7, 32'h58, "ch2_status_full");
    idle();
    req_read(2, 0, 9, "ch2_accepts");
    idle();
    cyc('0, 4'b0100, '1);
    add(2, 4, 11,    "ch2_lat_first_ts");
    add(2, 1, 1,     "ch2_dones");
    add(2, 7, 32'h57, "ch2_status_after_pop");
    run_tbl();

    // ch0 stall: done held four cycles without continue
    cyc(4'b0001, '0, '1);
    cyc('0, 4'b0001, 4'b1110);
    req_read(0, 7, 32'h21, "ch0_status_stall");
    cyc('0, 4'b0001, 4'b1110);
    cyc('0, 4'b0001, 4'b1110);
    cyc('0, 4'b0001, 4'b1110);
    cyc('0, 4'b0001, '1);
    add(0, 7, 0,  "ch0_status_idle");
    add(0, 3, 4,  "ch0_stall_cnt");
    add(0, 1, 2,  "ch0_dones2");
    add(0, 2, 13, "ch0_busy_excl_stall");
    add(0, 4, 5,  "ch0_last_lat2");
    add(0, 5, 5,  "ch0_min_lat2");
    add(0, 6, 12, "ch0_max_lat2");
    run_tbl();

    // ch3: start without ready, orphan done, then same-cycle bypass
    bus.ap_ready = 4'b0111;
    cyc(4'b1000, '0, '1);
    bus.ap_ready = '1;
    cyc('0, 4'b1000, '1);
    add(3, 0, 0,    "ch3_no_ready_accept");
    add(3, 1, 1,    "ch3_orphan_done");
    add(3, 5, ONES, "ch3_orphan_min");
    run_tbl();
    cyc(4'b1000, 4'b1000, '1);
    add(3, 0, 1, "ch3_bypass_accepts");
    add(3, 1, 2, "ch3_bypass_dones");
    add(3, 4, 0, "ch3_bypass_lat");
    add(3, 5, 0, "ch3_bypass_min");
    add(3, 2, 0, "ch3_bypass_busy");
    add(3, 7, 0, "ch3_bypass_status");
    run_tbl();

    // finish freezes statistics; readout keeps working
    bus.finish = 1'b1;
    idle();
    bus.finish = 1'b0;
    check("frozen_set", CNT_W'(bus.frozen), 1);
    repeat (5) cyc(4'b0001, '0, '1);
    add(0, 0, 2,      "frozen_ch0_accepts");
    add(2, 7, 32'h57, "frozen_ch2_status");
    run_tbl();
    check("frozen_sticky", CNT_W'(bus.frozen), 1);

    // clear releases the freeze and zeroes everything
    bus.clear = 1'b1;
    idle();
    bus.clear = 1'b0;
    check("clear_frozen", CNT_W'(bus.frozen), 0);
    check("clear_overflow", CNT_W'(bus.overflow), 0);
    add(0, 0, 0,    "clear_ch0_accepts");
    add(2, 7, 0,    "clear_ch2_status");
    add(1, 6, 0,    "clear_ch1_max");
    add(0, 5, ONES, "clear_ch0_min");
    add(NUM_CH, 0, 0, "unpopulated_channel");
    run_tbl();

    // reset with a transaction in flight; the later done is an orphan
    cyc(4'b0010, '0, '1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check("midreset_rd_data", bus.rd_data, 0);
    cyc('0, 4'b0010, '1);
    add(1, 0, 0,    "midreset_accepts");
    add(1, 1, 1,    "midreset_orphan_dones");
    add(1, 5, ONES, "midreset_min");
    add(1, 7, 0,    "midreset_status");
    run_tbl();

    idle();
    check("scoreboard_drained", CNT_W'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ap_handshake_perf_monitor.md
Name: ap_handshake_perf_monitor

Overview:
Parametrised successor to the per-module handshake and loop monitors. It observes NUM_CH independent ap_start/ap_ready/ap_done/ap_continue handshake sets. It supports pipelined blocks with multiple transactions in flight by timestamping each accepted start in a per-channel FIFO. It accumulates per-channel statistics (counts, busy/stall cycles, last/min/max latency), which are read back through a registered select port, so the simulation harness or an on-chip debug path can dump them after finish.

Parameters:
NUM_CH, 4, number of monitored handshake channels (1..16)
CNT_W, 32, width of timestamp and all statistic counters
DEPTH, 8, per-channel in-flight timestamp FIFO depth (power of 2, >=2)
CH_W, 4, width of rd_ch; must satisfy 2^CH_W >= NUM_CH

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
clear  in  1  synchronous stats/FIFO clear
finish  in  1  freeze request; sticky once sampled
ap_start  in  NUM_CH  per-channel start
ap_ready  in  NUM_CH  per-channel ready
ap_done  in  NUM_CH  per-channel done
ap_continue  in  NUM_CH  per-channel continue
rd_en  in  1  read request
rd_ch  in  CH_W  channel select
rd_sel  in  3  statistic select
rd_valid  out  1  read data valid
rd_data  out  CNT_W  read data
overflow  out  NUM_CH  sticky FIFO-overflow flag per channel
frozen  out  1  statistics frozen

Behaviour:
- Reset values: rd_valid=0, rd_data=0, overflow=0, frozen=0, ts=0, all FIFOs empty, counters 0, min_lat all-ones.
- ts: free-running CNT_W counter; wraps modulo 2^CNT_W; halts while frozen.
- Accept event ch: ap_start&ap_ready. Done event ch: ap_done&ap_continue. Both are sampled at the rising edge.
- Accept with FIFO not full: push ts.
- Accept with FIFO full: no push; overflow[ch] set sticky; accept count still increments.
- Done with FIFO non-empty: pop head; lat = (ts - head) mod 2^CNT_W; update last/min/max.
- Done with FIFO empty and no accept that cycle: orphan; done count increments; latency stats unchanged.
- Accept and done in the same cycle, FIFO empty: bypass, lat=0, nothing stored.
- Accept and done in the same cycle, FIFO non-empty: pop head, then push ts; occupancy unchanged; full flag irrelevant.
- Per-channel state, evaluated every cycle:
  - IDLE: FIFO empty.
  - BUSY: FIFO non-empty, not stalling. Busy count +1.
  - STALL: ap_done=1 and ap_continue=0. Stall count +1. STALL takes precedence over BUSY; busy count does not increment in STALL.
- Statistics saturate at all-ones; they never wrap.
- rd_sel map: 0 accepts, 1 dones, 2 busy cycles, 3 stall cycles, 4 last_lat, 5 min_lat (all-ones if no sample), 6 max_lat, 7 status.
  - status = {zero-pad, overflow[ch], state[1:0] (IDLE=0, BUSY=1, STALL=2), occupancy}.
- Readout: rd_en sampled at edge N. rd_valid=1 and rd_data valid during cycle N+1. Value is the pre-update value at edge N. rd_valid=0 otherwise; rd_data holds its last value. rd_ch >= NUM_CH returns 0 with rd_valid=1.
- clear: synchronous. Same effect as reset except rd_data. Clear wins over events in the same cycle. Clear also releases frozen.
- finish: when sampled high, frozen=1 from the next cycle. All FIFO, ts and stat updates stop. Readout remains functional. Frozen holds until reset or clear.
- Reset asserted mid-transaction: immediate clear. In-flight timestamps are discarded; a subsequent done is treated as orphan.

Test Plan:
- Single txn on ch0: accept at ts=5, done at ts=17 -> dones=1, last=min=max=12, busy=12, status occupancy 0.
- Pipelined ch1: accepts at ts 10,11,12, dones at ts 20,22,23 -> latencies 10,11,11; min=10, max=11, peak occupancy 3.
- Overflow, DEPTH=8: 9 accepts, no done -> overflow[2]=1, accepts=9, occupancy=8; a following done pops the ts of the 1st accept.
- Stall: ap_done=1 with ap_continue=0 for 4 cycles, then continue=1 -> stall=4, dones=1, state STALL→IDLE.
- Same-cycle accept+done on an empty ch3 -> last_lat=0, occupancy 0. Orphan done -> dones+1, min stays all-ones.
- Assert finish, then drive 5 more accepts; read sel0 -> value unchanged, frozen=1. Apply clear -> all zero, frozen=0.
- Read with rd_ch=NUM_CH -> rd_valid=1, rd_data=0.
